// File: rtl/alu_frame_issuer_pkg.sv
// Shared encodings for the ALU frame issuer.
// Op codes match the external 4-bit ALU; states cover one op/A/B frame.
package alu_frame_issuer_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } aluOp_t;

    typedef enum logic [2:0] {
        S_OP   = 3'd0,
        S_A    = 3'd1,
        S_B    = 3'd2,
        S_EXEC = 3'd3,
        S_OUT  = 3'd4
    } issueState_t;

    // An op nibble is well formed only when its upper two bits are clear.
    function automatic logic isOpNibble(input logic [3:0] nib);
        return nib[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/alu_frame_issuer.sv
// Collects op/A/B nibble frames, drives them onto the ALU,
// captures the answer and offers it downstream over valid/ready.
module alu_frame_issuer
    import alu_frame_issuer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             in_ready,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_ans,
    output logic             res_valid,
    output logic [3:0]       res_data,
    output logic [1:0]       res_op,
    input  logic             res_ready,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt
);

    issueState_t state;
    logic        xfer;

    // Upstream is open only while gathering nibbles, and never in reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            unique case (state)
                S_OP, S_A, S_B: in_ready = 1'b1;
                default:        in_ready = 1'b0;
            endcase
        end
    end

    assign xfer = in_valid && in_ready;

    // Frame sequencer; clr aborts any partial frame or pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OP;
            alu_op    <= 2'b00;
            alu_a     <= 4'h0;
            alu_b     <= 4'h0;
            res_valid <= 1'b0;
            res_data  <= 4'h0;
            res_op    <= 2'b00;
            err       <= 1'b0;
            frame_cnt <= '0;
        end else if (clr) begin
            state     <= S_OP;
            res_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                S_OP: begin
                    if (xfer) begin
                        if (isOpNibble(in_data)) begin
                            alu_op <= in_data[1:0];
                            state  <= S_A;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_A: begin
                    if (xfer) begin
                        alu_a <= in_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (xfer) begin
                        alu_b <= in_data;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_data  <= alu_ans;
                    res_op    <= alu_op;
                    res_valid <= 1'b1;
                    frame_cnt <= frame_cnt + 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_OP;
                    end
                end
                default: state <= S_OP;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_frame_issuer.sv
// Bench for alu_frame_issuer: directed scenarios plus randomized
// frames, with a behavioural ALU and frame model kept in the bench.
module tb_alu_frame_issuer;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rstN;
    logic             clr;
    logic             inValid;
    logic [3:0]       inData;
    logic             inReady;
    logic [1:0]       aluOp;
    logic [3:0]       aluA;
    logic [3:0]       aluB;
    logic [3:0]       aluAns;
    logic             resValid;
    logic [3:0]       resData;
    logic [1:0]       resOp;
    logic             resReady;
    logic             err;
    logic [CNT_W-1:0] frameCnt;

    int nVec  = 0;
    int nFail = 0;
    int expCnt = 0;

    alu_frame_issuer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rstN),
        .clr       (clr),
        .in_valid  (inValid),
        .in_data   (inData),
        .in_ready  (inReady),
        .alu_op    (aluOp),
        .alu_a     (aluA),
        .alu_b     (aluB),
        .alu_ans   (aluAns),
        .res_valid (resValid),
        .res_data  (resData),
        .res_op    (resOp),
        .res_ready (resReady),
        .err       (err),
        .frame_cnt (frameCnt)
    );

    // Reference arithmetic for the 4-bit ALU sitting beside the block.
    function automatic logic [3:0] refAlu(input logic [1:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        int r;
        case (op)
            2'd0:    r = a & b;
            2'd1:    r = a | b;
            2'd2:    r = a ^ b;
            default: r = (int'(a) + int'(b)) % 16;
        endcase
        return 4'(r);
    endfunction

    assign aluAns = refAlu(aluOp, aluA, aluB);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] cntExp();
        return CNT_W'(expCnt % (1 << CNT_W));
    endfunction

    // Offer one nibble and wait (bounded) until it is taken.
    task automatic sendNib(input logic [3:0] d);
        int n = 0;
        inValid = 1'b1;
        inData  = d;
        while (!inReady && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        nVec++;
        if (!inReady) begin
            nFail++;
            $display("FAIL send_timeout in_ready=%b want 1", inReady);
        end
        @(posedge clk); #1;
        inValid = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0; clr = 1'b0; inValid = 1'b0;
        inData = 4'h0; resReady = 1'b0;
        #2;
        nVec++;
        if (inReady !== 1'b0) begin
            nFail++;
            $display("FAIL reset_in_ready got %b want 0", inReady);
        end
        nVec++;
        if ({resValid, resData, resOp, err, frameCnt, aluOp, aluA, aluB} !== '0) begin
            nFail++;
            $display("FAIL reset_outputs got %b want 0",
                     {resValid, resData, resOp, err, frameCnt, aluOp, aluA, aluB});
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        nVec++;
        if (inReady !== 1'b1) begin
            nFail++;
            $display("FAIL reset_release_ready got %b want 1", inReady);
        end
    endtask

    task automatic test_basic();
        resReady = 1'b1;
        sendNib(4'h0); sendNib(4'hC); sendNib(4'hA);
        nVec++;
        if ({aluOp, aluA, aluB, resValid} !== {2'b00, 4'hC, 4'hA, 1'b0}) begin
            nFail++;
            $display("FAIL basic_operands got %b want %b",
                     {aluOp, aluA, aluB, resValid}, {2'b00, 4'hC, 4'hA, 1'b0});
        end
        @(posedge clk); #1;
        expCnt++;
        nVec++;
        if ({resValid, resData, resOp, frameCnt} !== {1'b1, 4'b1000, 2'b00, cntExp()}) begin
            nFail++;
            $display("FAIL basic_result got %b want %b",
                     {resValid, resData, resOp, frameCnt}, {1'b1, 4'b1000, 2'b00, cntExp()});
        end
        @(posedge clk); #1;
        nVec++;
        if ({resValid, inReady} !== 2'b01) begin
            nFail++;
            $display("FAIL basic_drain got %b want 01", {resValid, inReady});
        end
    endtask

    task automatic test_add_overflow();
        resReady = 1'b1;
        sendNib(4'h3); sendNib(4'hF); sendNib(4'h2);
        @(posedge clk); #1;
        expCnt++;
        nVec++;
        if ({resValid, resData, resOp, frameCnt} !== {1'b1, 4'b0001, 2'b11, cntExp()}) begin
            nFail++;
            $display("FAIL add_overflow got %b want %b",
                     {resValid, resData, resOp, frameCnt}, {1'b1, 4'b0001, 2'b11, cntExp()});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        resReady = 1'b0;
        sendNib(4'h2); sendNib(4'h5); sendNib(4'h3);
        @(posedge clk); #1;
        expCnt++;
        for (int i = 0; i < 5; i++) begin
            nVec++;
            if ({resValid, resData, resOp, inReady} !== {1'b1, 4'b0110, 2'b10, 1'b0}) begin
                nFail++;
                $display("FAIL stall_hold cyc=%0d got %b want %b", i,
                         {resValid, resData, resOp, inReady}, {1'b1, 4'b0110, 2'b10, 1'b0});
            end
            if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        resReady = 1'b1;
        @(posedge clk); #1;
        nVec++;
        if ({resValid, inReady} !== 2'b01) begin
            nFail++;
            $display("FAIL stall_release got %b want 01", {resValid, inReady});
        end
    endtask

    task automatic test_malformed();
        resReady = 1'b1;
        inValid = 1'b1; inData = 4'h6;
        @(posedge clk); #1;
        inValid = 1'b0;
        nVec++;
        if ({err, inReady, aluOp} !== {1'b1, 1'b1, 2'b10}) begin
            nFail++;
            $display("FAIL malformed_err got %b want 1110", {err, inReady, aluOp});
        end
        @(posedge clk); #1;
        nVec++;
        if (err !== 1'b0) begin
            nFail++;
            $display("FAIL malformed_pulse got %b want 0", err);
        end
        sendNib(4'h1); sendNib(4'h9); sendNib(4'h6);
        @(posedge clk); #1;
        expCnt++;
        nVec++;
        if ({resValid, resData, resOp, frameCnt} !== {1'b1, 4'b1111, 2'b01, cntExp()}) begin
            nFail++;
            $display("FAIL malformed_next got %b want %b",
                     {resValid, resData, resOp, frameCnt}, {1'b1, 4'b1111, 2'b01, cntExp()});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clr();
        resReady = 1'b1;
        sendNib(4'h1); sendNib(4'h3);
        clr = 1'b1; inValid = 1'b1; inData = 4'h7;
        @(posedge clk); #1;
        clr = 1'b0; inValid = 1'b0;
        nVec++;
        if ({inReady, resValid, err, aluOp, aluA, aluB, frameCnt} !==
            {1'b1, 1'b0, 1'b0, 2'b01, 4'h3, 4'h6, cntExp()}) begin
            nFail++;
            $display("FAIL clr_abort got %b want %b",
                     {inReady, resValid, err, aluOp, aluA, aluB, frameCnt},
                     {1'b1, 1'b0, 1'b0, 2'b01, 4'h3, 4'h6, cntExp()});
        end
        sendNib(4'h0); sendNib(4'hF); sendNib(4'h3);
        @(posedge clk); #1;
        expCnt++;
        nVec++;
        if ({resValid, resData, frameCnt} !== {1'b1, 4'b0011, cntExp()}) begin
            nFail++;
            $display("FAIL clr_next_frame got %b want %b",
                     {resValid, resData, frameCnt}, {1'b1, 4'b0011, cntExp()});
        end
        @(posedge clk); #1;
        resReady = 1'b0;
        sendNib(4'h3); sendNib(4'h1); sendNib(4'h1);
        @(posedge clk); #1;
        expCnt++;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        nVec++;
        if ({resValid, inReady, frameCnt} !== {1'b0, 1'b1, cntExp()}) begin
            nFail++;
            $display("FAIL clr_drop_result got %b want %b",
                     {resValid, inReady, frameCnt}, {1'b0, 1'b1, cntExp()});
        end
    endtask

    task automatic test_reset_mid();
        resReady = 1'b0;
        sendNib(4'h1); sendNib(4'h2); sendNib(4'h4);
        @(posedge clk); #1;
        rstN = 1'b0;
        #1;
        expCnt = 0;
        nVec++;
        if ({resValid, resData, resOp, err, frameCnt, aluOp, aluA, aluB, inReady} !== '0) begin
            nFail++;
            $display("FAIL reset_mid got %b want 0",
                     {resValid, resData, resOp, err, frameCnt, aluOp, aluA, aluB, inReady});
        end
        #2;
        rstN = 1'b1;
        @(posedge clk); #1;
        nVec++;
        if ({inReady, resValid} !== 2'b10) begin
            nFail++;
            $display("FAIL reset_mid_release got %b want 10", {inReady, resValid});
        end
    endtask

    // Random frames with random stalls and malformed op nibbles.
    task automatic test_random(input int frames, input int badPct);
        logic [3:0] nib, a, b;
        logic [3:0] expRes;
        int k;
        for (int f = 0; f < frames; f++) begin
            resReady = 1'b0;
            nib = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < badPct)
                nib = 4'($urandom_range(4, 15));
            if (nib[3:2] != 2'b00) begin
                inValid = 1'b1; inData = nib;
                @(posedge clk); #1;
                inValid = 1'b0;
                nVec++;
                if ({err, inReady} !== 2'b11) begin
                    nFail++;
                    $display("FAIL rand_bad_op nib=%h got %b want 11", nib, {err, inReady});
                end
                continue;
            end
            a = 4'($urandom);
            b = 4'($urandom);
            expRes = refAlu(nib[1:0], a, b);
            sendNib(nib); sendNib(a); sendNib(b);
            @(posedge clk); #1;
            expCnt++;
            k = $urandom_range(0, 3);
            for (int i = 0; i <= k; i++) begin
                nVec++;
                if ({resValid, resData, resOp, frameCnt, inReady} !==
                    {1'b1, expRes, nib[1:0], cntExp(), 1'b0}) begin
                    nFail++;
                    $display("FAIL rand_result f=%0d got %b want %b", f,
                             {resValid, resData, resOp, frameCnt, inReady},
                             {1'b1, expRes, nib[1:0], cntExp(), 1'b0});
                end
                if (i < k) begin
                    @(posedge clk); #1;
                end
            end
            resReady = 1'b1;
            @(posedge clk); #1;
            nVec++;
            if ({resValid, inReady, err} !== 3'b010) begin
                nFail++;
                $display("FAIL rand_drain f=%0d got %b want 010", f, {resValid, inReady, err});
            end
        end
    endtask

    task automatic test_wrap();
        test_random(5, 0);
        nVec++;
        if (frameCnt !== CNT_W'(1)) begin
            nFail++;
            $display("FAIL wrap_count got %0d want 1", frameCnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_add_overflow();
        test_backpressure();
        test_malformed();
        test_clr();
        test_reset_mid();
        test_wrap();
        test_random(40, 25);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
